// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp_if
//  Description : Bus bundle for the multi-port register file. It groups the
//                write ports, read ports, busy-set request and status
//                outputs.
//                  ready     - block initialised and accepting traffic
//                  we/waddr/wdata        - NWR packed write ports
//                  re/raddr/rdata/rbusy  - NRD packed read ports
//                  bset_en/bset_addr     - mark a register as busy
//                master : traffic source (drives requests)
//                slave  : register file (drives ready/rdata/rbusy)
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 4,
  parameter int NWR    = 2
) ();

  logic                   ready;
  logic [NWR-1:0]         we;
  logic [NWR*ADDR_W-1:0]  waddr;
  logic [NWR*DATA_W-1:0]  wdata;
  logic [NRD-1:0]         re;
  logic [NRD*ADDR_W-1:0]  raddr;
  logic [NRD*DATA_W-1:0]  rdata;
  logic                   bset_en;
  logic [ADDR_W-1:0]      bset_addr;
  logic [NRD-1:0]         rbusy;

  modport master (
    input  ready, rdata, rbusy,
    output we, waddr, wdata, re, raddr, bset_en, bset_addr
  );

  modport slave (
    output ready, rdata, rbusy,
    input  we, waddr, wdata, re, raddr, bset_en, bset_addr
  );

endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-port register file with NWR write ports, NRD
//                combinational read ports, write-to-read bypass and a
//                per-register busy scoreboard. Register 0 is hardwired to
//                zero. After reset, an INIT sequence clears r1..r(NREG-1),
//                one register per cycle, and then the block raises ready.
//  Ports       : clk    - clock, rising edge
//                resetn - synchronous active-low reset
//                bus    - regfile_mp_if.slave (write/read/busy-set traffic)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 4,
  parameter int NWR    = 2
) (
  input  wire logic   clk,
  input  wire logic   resetn,
  regfile_mp_if.slave bus
);

  localparam int ADDR_W = $clog2(NREG);
  // The init counter is at least 5 bits wide.
  localparam int CNT_W  = (ADDR_W > 5) ? ADDR_W : 5;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ready;
  logic [NREG-1:0]     r_busy;
  logic [NREG-1:0]     w_busy_nxt;
  logic [DATA_W-1:0]   r_mem [NREG];

  logic [ADDR_W-1:0]   w_waddr [NWR];
  logic [DATA_W-1:0]   w_wdata [NWR];
  logic                w_active;

  // Outputs are forced to zero while reset is held or INIT is running.
  assign w_active  = resetn && r_ready;
  assign bus.ready = r_ready;

  for (genvar i = 0; i < NWR; i++) begin : g_wr_unpack
    assign w_waddr[i] = bus.waddr[i*ADDR_W +: ADDR_W];
    assign w_wdata[i] = bus.wdata[i*DATA_W +: DATA_W];
  end

  // --------------------------------------------------------------------------
  // Control FSM: INIT walks cnt from 1 to NREG-1, then the FSM moves to RUN.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_INIT;
      r_cnt   <= CNT_W'(1);
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_RUN);
      if (r_state == ST_INIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: begin
        if (r_cnt == CNT_W'(NREG-1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Storage array. It has no reset. INIT clears it one entry per cycle.
  // Entry 0 is never written and never read through: raddr==0 always
  // returns zero. In the loop, later (higher-index) ports overwrite earlier
  // ones, so the highest-index port wins a write conflict.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (r_state == ST_INIT) begin
        r_mem[r_cnt[ADDR_W-1:0]] <= '0;
      end else begin
        for (int i = 0; i < NWR; i++) begin
          if (bus.we[i] && (w_waddr[i] != '0)) begin
            r_mem[w_waddr[i]] <= w_wdata[i];
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Busy scoreboard. Writes clear the bit first and a bset then sets it, so
  // a new producer overrides a write that completes in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NWR; i++) begin
      if (bus.we[i]) begin
        w_busy_nxt[w_waddr[i]] = 1'b0;
      end
    end
    if (bus.bset_en) begin
      w_busy_nxt[bus.bset_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_busy <= '0;
    end else if (r_state == ST_RUN) begin
      r_busy <= w_busy_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports. They are combinational and bypass data from same-cycle
  // writes. A same-cycle write to the address also hides its busy bit.
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_re;
    logic              w_hit;
    logic [DATA_W-1:0] w_fwd;

    assign w_ra = bus.raddr[j*ADDR_W +: ADDR_W];
    assign w_re = bus.re[j];

    always_comb begin
      w_hit = 1'b0;
      w_fwd = '0;
      for (int i = 0; i < NWR; i++) begin
        if (bus.we[i] && (w_waddr[i] == w_ra)) begin
          w_hit = 1'b1;
          w_fwd = w_wdata[i];
        end
      end
    end

    assign bus.rdata[j*DATA_W +: DATA_W] =
      (!w_active || !w_re || (w_ra == '0)) ? '0 :
      (w_hit ? w_fwd : r_mem[w_ra]);

    assign bus.rbusy[j] = w_active && w_re && r_busy[w_ra] && !w_hit;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Testbench for regfile_mp (NREG=32, NWR=2, NRD=4,
//                DATA_W=32). A stimulus process drives each cycle just after
//                the rising edge and queues the expected outputs. A monitor
//                process pops the queued expectations on the falling edge and
//                compares them with the DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NW = 2;

  logic clk;
  logic resetn;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW)) bus ();

  regfile_mp #(.DATA_W(DW), .NREG(32), .NRD(NR), .NWR(NW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = rdata[port], 1 = rbusy[port], 2 = ready
  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] exp;
  } chk_t;

  chk_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string tag     = "";

  function automatic void push(input int kind, input int port, input logic [31:0] e);
    chk_t c;
    c.name = (kind == 2) ? $sformatf("%s ready", tag) :
             (kind == 0) ? $sformatf("%s rdata%0d", tag, port) :
                           $sformatf("%s rbusy%0d", tag, port);
    c.kind = kind;
    c.port = port;
    c.exp  = e;
    sb.push_back(c);
  endfunction

  function automatic void exp_rd(input int j, input logic [31:0] v);   push(0, j, v); endfunction
  function automatic void exp_busy(input int j, input logic v);        push(1, j, {31'd0, v}); endfunction
  function automatic void exp_ready(input logic v);                    push(2, 0, {31'd0, v}); endfunction

  // Monitor: drains every expectation queued for the current cycle.
  always @(negedge clk) begin : mon
    chk_t        c;
    logic [31:0] act;
    while (sb.size() != 0) begin
      c = sb.pop_front();
      case (c.kind)
        0:       act = bus.rdata[c.port*DW +: DW];
        1:       act = {31'd0, bus.rbusy[c.port]};
        default: act = {31'd0, bus.ready};
      endcase
      n_tests++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h at %0t", c.name, act, c.exp, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we        = '0;
    bus.waddr     = '0;
    bus.wdata     = '0;
    bus.re        = '0;
    bus.raddr     = '0;
    bus.bset_en   = 1'b0;
    bus.bset_addr = '0;
  endtask

  task automatic set_wr(input int i, input int a, input logic [31:0] d);
    logic [AW-1:0] a5;
    a5 = AW'(a);
    bus.we[i]             = 1'b1;
    bus.waddr[i*AW +: AW] = a5;
    bus.wdata[i*DW +: DW] = d;
  endtask

  task automatic set_rd(input int j, input int a, input logic en);
    logic [AW-1:0] a5;
    a5 = AW'(a);
    bus.re[j]             = en;
    bus.raddr[j*AW +: AW] = a5;
  endtask

  task automatic bset(input int a);
    bus.bset_en   = 1'b1;
    bus.bset_addr = AW'(a);
  endtask

  // Reset and INIT sequence. If abort_k > 0, resetn is pulsed again after
  // abort_k INIT cycles (cnt == abort_k+1 at that edge). Writes and bsets
  // stay active throughout INIT, and INIT must ignore them.
  task automatic do_init(input int abort_k);
    tag = "reset";
    idle();
    set_rd(1, 20, 1'b1);
    resetn = 1'b0;
    exp_rd(1, 32'h0);
    exp_busy(1, 1'b0);
    set_wr(0, 9, 32'hAAAA5555);
    bset(9);
    set_rd(0, 9, 1'b1);
    step();
    exp_ready(1'b0);
    exp_rd(0, 32'h0);
    exp_busy(0, 1'b0);
    resetn = 1'b1;
    if (abort_k > 0) begin
      tag = "init-abort";
      for (int k = 1; k <= abort_k; k++) begin
        step();
        exp_ready(1'b0);
        exp_rd(0, 32'h0);
      end
      resetn = 1'b0;
      step();
      exp_ready(1'b0);
      exp_busy(0, 1'b0);
      resetn = 1'b1;
    end
    tag = "init";
    for (int k = 1; k <= 31; k++) begin
      step();
      if (k == 31) begin
        idle();
        exp_ready(1'b1);
      end else begin
        exp_ready(1'b0);
        exp_rd(0, 32'h0);
        exp_busy(0, 1'b0);
      end
    end
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    do_init(0);

    // All registers read zero after INIT, and r9 is not busy.
    tag = "zero";
    for (int b = 0; b < 8; b++) begin
      step(); idle();
      for (int j = 0; j < NR; j++) begin
        set_rd(j, b*4 + j, 1'b1);
        exp_rd(j, 32'h0);
        exp_busy(j, 1'b0);
      end
    end

    // Same-address write conflict: the higher port wins.
    tag = "conflict";
    step(); idle();
    set_wr(0, 5, 32'h11111111); set_wr(1, 5, 32'h22222222);
    set_rd(0, 5, 1'b1);
    exp_rd(0, 32'h22222222); exp_busy(0, 1'b0);
    step(); idle();
    set_rd(0, 5, 1'b1);
    exp_rd(0, 32'h22222222);

    // Independent writes on both ports, with bypass and then array reads.
    tag = "dual";
    step(); idle();
    set_wr(0, 6, 32'h66666666); set_wr(1, 8, 32'h88888888);
    set_rd(0, 6, 1'b1); set_rd(1, 8, 1'b1); set_rd(2, 5, 1'b1);
    exp_rd(0, 32'h66666666); exp_rd(1, 32'h88888888); exp_rd(2, 32'h22222222);
    step(); idle();
    set_rd(0, 6, 1'b1); set_rd(1, 8, 1'b1);
    exp_rd(0, 32'h66666666); exp_rd(1, 32'h88888888);

    // Register 0 stores nothing and is never busy.
    tag = "r0";
    step(); idle();
    set_wr(0, 0, 32'hDEADBEEF); bset(0);
    set_rd(0, 0, 1'b1);
    exp_rd(0, 32'h0); exp_busy(0, 1'b0);
    step(); idle();
    set_rd(0, 0, 1'b1);
    exp_rd(0, 32'h0); exp_busy(0, 1'b0);

    // Busy timing on r7.
    tag = "busy-t";
    step(); idle();
    bset(7); set_rd(1, 7, 1'b1);
    exp_rd(1, 32'h0); exp_busy(1, 1'b0);
    tag = "busy-t1";
    step(); idle(); set_rd(1, 7, 1'b1); exp_busy(1, 1'b1);
    tag = "busy-t2";
    step(); idle(); set_rd(1, 7, 1'b1); exp_busy(1, 1'b1);
    tag = "busy-t3";
    step(); idle();
    set_wr(0, 7, 32'h77777777); set_rd(1, 7, 1'b1);
    exp_rd(1, 32'h77777777); exp_busy(1, 1'b0);
    tag = "busy-t4";
    step(); idle(); set_rd(1, 7, 1'b1);
    exp_rd(1, 32'h77777777); exp_busy(1, 1'b0);
    tag = "set+clr";
    step(); idle();
    bset(7); set_wr(1, 7, 32'h12345678); set_rd(1, 7, 1'b1);
    exp_rd(1, 32'h12345678); exp_busy(1, 1'b0);
    tag = "set-wins";
    step(); idle(); set_rd(1, 7, 1'b1);
    exp_rd(1, 32'h12345678); exp_busy(1, 1'b1);

    // A port-1 write to r0 is dropped and does not disturb a port-0 write.
    tag = "wr-r0-p1";
    step(); idle();
    set_wr(0, 10, 32'hA0A0A0A0); set_wr(1, 0, 32'hFFFFFFFF);
    set_rd(3, 10, 1'b1); set_rd(2, 0, 1'b1);
    exp_rd(3, 32'hA0A0A0A0); exp_rd(2, 32'h0);
    step(); idle(); set_rd(3, 10, 1'b1);
    exp_rd(3, 32'hA0A0A0A0);

    // A disabled read port returns zero and is not busy, even on a busy register.
    tag = "re-off";
    step(); idle();
    set_wr(0, 3, 32'h0000ABCD); bset(3);
    step(); idle();
    set_rd(2, 3, 1'b0); set_rd(3, 3, 1'b1);
    exp_rd(2, 32'h0); exp_busy(2, 1'b0);
    exp_rd(3, 32'h0000ABCD); exp_busy(3, 1'b1);

    // Load r20 with data and set it busy, then reset in the middle of INIT.
    tag = "pre-reset";
    step(); idle();
    set_wr(0, 20, 32'h00001234); bset(20);
    step(); idle(); set_rd(0, 20, 1'b1);
    exp_rd(0, 32'h00001234); exp_busy(0, 1'b1);
    step();
    do_init(9);

    tag = "post-reset";
    step(); idle();
    set_rd(0, 20, 1'b1); set_rd(1, 9, 1'b1); set_rd(2, 7, 1'b1);
    exp_rd(0, 32'h0); exp_busy(0, 1'b0);
    exp_rd(1, 32'h0); exp_busy(1, 1'b0);
    exp_rd(2, 32'h0); exp_busy(2, 1'b0);

    step(); idle();
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard-drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter NREG, default 32, number of registers; power of two, at least 4; ADDR_W = clog2(NREG).
REQ-003 Parameter NRD, default 4, number of read ports; range 1..8.
REQ-004 Parameter NWR, default 2, number of write ports; range 1..4.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 resetn  input  1  reset; synchronous, active-low.
REQ-007 ready  output  1  high when initialisation is complete and the block accepts traffic.
REQ-008 we  input  NWR  per-port write enable.
REQ-009 waddr  input  NWR*ADDR_W  write addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 wdata  input  NWR*DATA_W  write data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-011 re  input  NRD  per-port read enable.
REQ-012 raddr  input  NRD*ADDR_W  read addresses, packed the same way as waddr.
REQ-013 rdata  output  NRD*DATA_W  read data, packed the same way as wdata.
REQ-014 bset_en  input  1  marks register bset_addr as awaiting a producer (busy).
REQ-015 bset_addr  input  ADDR_W  register to mark busy.
REQ-016 rbusy  output  NRD  per-read-port busy flag.

Function
REQ-017 Register 0 SHALL read as zero, never store data and never be busy.
REQ-018 FSM states: INIT, RUN.
REQ-019 INIT: 5-bit-or-wider counter cnt starts at 1; each cycle writes zero to reg[cnt] and increments cnt.
REQ-020 INIT to RUN transition: on the edge where reg[NREG-1] is cleared; INIT lasts exactly NREG-1 cycles after resetn is released.
REQ-021 ready SHALL be 0 in INIT and 1 in RUN; it is a registered output.
REQ-022 In INIT, the block SHALL ignore we and bset_en, and rdata and rbusy SHALL be all zero.
REQ-023 RUN write: at the rising edge, for each port i with we[i]=1 and waddr_i != 0, the block SHALL store wdata_i into reg[waddr_i].
REQ-024 Write conflict: when several enabled ports target one address in the same cycle, the highest-index port SHALL win.
REQ-025 RUN read (combinational), per port j, first match wins:
- raddr_j = 0 -> zero;
- re_j = 0 -> zero;
- raddr_j equals an enabled write address -> that wdata, highest-index port wins;
- otherwise -> reg[raddr_j].
REQ-026 Busy state: one bit per register, named busy.
- bset_en with bset_addr != 0 SHALL set busy[bset_addr] at the next edge.
- An enabled write to address a SHALL clear busy[a] at the next edge.
REQ-027 Simultaneous set and clear of the same address: set SHALL win, because a new producer supersedes the old one.
REQ-028 rbusy_j SHALL be re_j AND busy[raddr_j] AND NOT (an enabled write to raddr_j this cycle).
REQ-029 A bset issued in a cycle SHALL NOT be visible on rbusy until the following cycle.
REQ-030 Read latency SHALL be zero cycles; write-to-array latency SHALL be one edge.

Reset
REQ-031 resetn=0 at any edge, including mid-INIT or mid-write, SHALL set:
- state INIT, cnt=1, ready=0;
- all busy bits 0.
All writes in that cycle SHALL be discarded.
REQ-032 While resetn=0, rdata and rbusy SHALL be zero.
REQ-033 Register contents SHALL be defined (zero) only after INIT completes; no reset-time array clear is required.

Verification (NREG=32, NWR=2, NRD=4, DATA_W=32)
REQ-034 Release resetn, count cycles: ready rises after exactly 31 cycles, and reads of r1..r31 then return 0x00000000.
REQ-035 Port0 and port1 both write r5 (0x11111111 and 0x22222222): same-cycle read of r5 returns 0x22222222; next cycle the array holds 0x22222222.
REQ-036 Write r0=0xDEADBEEF with bset r0: read r0 returns 0, and rbusy stays 0.
REQ-037 bset r7 at cycle t: rbusy for r7 is 0 at t and 1 at t+1.
- Write r7 at t+3: rbusy 0 at t+3, and read returns the write data.
- Concurrent bset r7 and write r7: rbusy=1 in the next cycle.
REQ-038 Assert resetn=0 for one cycle at INIT cnt=10: the full 31-cycle INIT restarts, and bset/we issued during INIT have no effect.
REQ-039 re_j=0 with raddr_j=3 holding 0x0000ABCD and busy: rdata_j=0 and rbusy_j=0.
